// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants, state encoding and small helpers for the multiplexed
// seven-segment scan decoder.
package seg_scan_decoder_pkg;

  localparam logic [6:0] SEG_PAT_0 = 7'h40;
  localparam logic [6:0] SEG_PAT_1 = 7'h79;
  localparam logic [6:0] SEG_PAT_2 = 7'h24;
  localparam logic [6:0] SEG_PAT_3 = 7'h30;
  localparam logic [6:0] SEG_PAT_4 = 7'h19;
  localparam logic [6:0] SEG_PAT_5 = 7'h12;
  localparam logic [6:0] SEG_PAT_6 = 7'h02;
  localparam logic [6:0] SEG_PAT_7 = 7'h78;
  localparam logic [6:0] SEG_PAT_8 = 7'h00;
  localparam logic [6:0] SEG_PAT_9 = 7'h10;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] AN_NONE    = 4'hF;
  localparam logic [6:0] SEG_DARK   = 7'h7F;

  localparam int DEFAULT_SETTLE_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_t;

  // An anode word selects a digit only when exactly one line is driven low.
  function automatic logic an_is_valid(input logic [3:0] an);
    logic [3:0] low;
    low = ~an;
    return (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] an_slot(input logic [3:0] an);
    logic [1:0] slot;
    case (an)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: slot = 2'd0;
    endcase
    return slot;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Scan-side inputs and decoded-digit outputs of the scan decoder, bundled so
// the display source (master) and the decoder (slave) share one port.
interface seg_scan_decoder_if;

  logic [3:0] an;
  logic [6:0] Seg;
  logic [3:0] Minutes;
  logic [3:0] Tens_Seconds;
  logic [3:0] Ones_Seconds;
  logic [3:0] Tenths_Seconds;
  logic       frame_valid;
  logic       seg_error;

  modport master (
    output an, Seg,
    input  Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds,
    input  frame_valid, seg_error
  );

  modport slave (
    input  an, Seg,
    output Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds,
    output frame_valid, seg_error
  );

endinterface

// File: rtl/seg7_to_bcd.sv
// Combinational decode of an active-low {g..a} segment pattern into a BCD
// digit; anything that is not one of the ten digit glyphs flags invalid.
module seg7_to_bcd
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       invalid
);

  always_comb begin
    digit   = BLANK_CODE;
    invalid = 1'b0;
    case (seg)
      SEG_PAT_0: digit = 4'd0;
      SEG_PAT_1: digit = 4'd1;
      SEG_PAT_2: digit = 4'd2;
      SEG_PAT_3: digit = 4'd3;
      SEG_PAT_4: digit = 4'd4;
      SEG_PAT_5: digit = 4'd5;
      SEG_PAT_6: digit = 4'd6;
      SEG_PAT_7: digit = 4'd7;
      SEG_PAT_8: digit = 4'd8;
      SEG_PAT_9: digit = 4'd9;
      default: begin
        digit   = BLANK_CODE;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the four BCD digits from a multiplexed seven-segment scan.
// Optional macro SEG_SCAN_STABLE_EN: commit a frame only when it repeats the previous one.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input logic clk,
  input logic reset,
  seg_scan_decoder_if.slave bus
);

  localparam logic [7:0] SETTLE_LIMIT = 8'(SETTLE_CYCLES);

  logic [3:0]       an_q;
  logic [3:0]       an_d;
  logic [6:0]       seg_q;
  logic [6:0]       seg_d;
  scan_state_t      state;
  logic [7:0]       count;
  logic [3:0]       seen;
  logic [3:0][3:0]  shadow;
  logic [3:0][3:0]  digits_q;
  logic             frame_valid_q;
  logic             seg_error_q;

`ifdef SEG_SCAN_STABLE_EN
  logic [3:0][3:0]  prev_frame;
  logic             prev_valid;
`endif

  logic             an_ok;
  logic             changed;
  logic             fresh;
  logic             capture;
  logic             frame_done;
  logic [7:0]       count_next;
  logic [1:0]       slot;
  logic [3:0]       dec_digit;
  logic             dec_invalid;
  logic [3:0]       seen_next;
  logic [3:0][3:0]  shadow_next;

  seg7_to_bcd u_decode (
    .seg     (seg_q),
    .digit   (dec_digit),
    .invalid (dec_invalid)
  );

  // A dwell starts fresh on leaving IDLE or on any change of anode/segments;
  // capture fires once, on the cycle the stable count reaches the limit.
  always_comb begin
    an_ok       = an_is_valid(an_q);
    changed     = (an_q != an_d) || (seg_q != seg_d);
    fresh       = (state == ST_IDLE) || changed;
    count_next  = fresh ? 8'd1 : count + 8'd1;
    capture     = an_ok && ((state != ST_HELD) || changed) && (count_next == SETTLE_LIMIT);
    slot        = an_slot(an_q);
    shadow_next = shadow;
    seen_next   = seen;
    if (capture) begin
      shadow_next[slot] = dec_digit;
      seen_next[slot]   = 1'b1;
    end
    frame_done  = capture && (seen_next == 4'hF);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_q          <= AN_NONE;
      an_d          <= AN_NONE;
      seg_q         <= SEG_DARK;
      seg_d         <= SEG_DARK;
      state         <= ST_IDLE;
      count         <= 8'd0;
      seen          <= 4'd0;
      shadow        <= '0;
      digits_q      <= '0;
      frame_valid_q <= 1'b0;
      seg_error_q   <= 1'b0;
`ifdef SEG_SCAN_STABLE_EN
      prev_frame    <= '0;
      prev_valid    <= 1'b0;
`endif
    end else begin
      an_q          <= bus.an;
      seg_q         <= bus.Seg;
      an_d          <= an_q;
      seg_d         <= seg_q;
      frame_valid_q <= 1'b0;
      seg_error_q   <= capture && dec_invalid;
      shadow        <= shadow_next;

      if (!an_ok) begin
        state <= ST_IDLE;
        count <= 8'd0;
      end else if (capture) begin
        state <= ST_HELD;
        count <= count_next;
      end else if ((state != ST_HELD) || changed) begin
        state <= ST_SETTLE;
        count <= count_next;
      end

      // The fourth distinct slot completes the frame; partial data never
      // reaches the outputs.
      if (frame_done) begin
        seen <= 4'd0;
`ifdef SEG_SCAN_STABLE_EN
        if (prev_valid && (prev_frame == shadow_next)) begin
          digits_q      <= shadow_next;
          frame_valid_q <= 1'b1;
        end
        prev_frame <= shadow_next;
        prev_valid <= 1'b1;
`else
        digits_q      <= shadow_next;
        frame_valid_q <= 1'b1;
`endif
      end else begin
        seen <= seen_next;
      end
    end
  end

  assign bus.Minutes        = digits_q[3];
  assign bus.Tens_Seconds   = digits_q[2];
  assign bus.Ones_Seconds   = digits_q[1];
  assign bus.Tenths_Seconds = digits_q[0];
  assign bus.frame_valid    = frame_valid_q;
  assign bus.seg_error      = seg_error_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scan scenarios plus a
// randomized scan checked against a run-length model of the display.
module tb_seg_scan_decoder;

  localparam int SETTLE = 4;

  logic clk;
  logic reset;

  seg_scan_decoder_if bus ();

  seg_scan_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared;
  int n_mismatched;
  int pulse_skew;
  int fv_obs, fv_exp, err_obs, err_exp;

  logic [6:0] pat [10];

  // Reference model: the display as a sequence of runs of identical samples.
  logic [3:0] m_last_an;
  logic [6:0] m_last_seg;
  int         m_run;
  logic [3:0] m_shadow [4];
  logic [3:0] m_seen;
  logic [3:0] m_out [4];
  logic [3:0] m_prev [4];
  logic       m_prev_valid;
  logic       pend_cap;
  int         pend_slot;
  logic [3:0] pend_digit;

  function automatic bit an_valid(input logic [3:0] a);
    return $countones(~a) == 1;
  endfunction

  function automatic int an_index(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (!a[i]) return i;
    return 0;
  endfunction

  function automatic logic [3:0] decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (pat[i] == s) return 4'(i);
    return 4'hF;
  endfunction

  function automatic logic [3:0] dut_digit(input int i);
    case (i)
      3:       return bus.Minutes;
      2:       return bus.Tens_Seconds;
      1:       return bus.Ones_Seconds;
      default: return bus.Tenths_Seconds;
    endcase
  endfunction

  task automatic model_reset();
    m_last_an    = 4'hF;
    m_last_seg   = 7'h7F;
    m_run        = 0;
    m_seen       = 4'd0;
    m_prev_valid = 1'b0;
    pend_cap     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 4'd0;
      m_out[i]    = 4'd0;
      m_prev[i]   = 4'd0;
    end
  endtask

  task automatic model_commit(output logic fv);
    bit same;
    fv   = 1'b0;
    same = m_prev_valid;
    for (int i = 0; i < 4; i++) if (m_prev[i] != m_shadow[i]) same = 0;
`ifdef SEG_SCAN_STABLE_EN
    if (same) begin
      for (int i = 0; i < 4; i++) m_out[i] = m_shadow[i];
      fv = 1'b1;
    end
`else
    for (int i = 0; i < 4; i++) m_out[i] = m_shadow[i];
    fv = 1'b1;
`endif
    for (int i = 0; i < 4; i++) m_prev[i] = m_shadow[i];
    m_prev_valid = 1'b1;
  endtask

  // Drives one clock of input, advances the model, and tallies pulse agreement.
  task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input logic r);
    logic exp_fv, exp_err;
    bus.an  = a;
    bus.Seg = s;
    reset   = r;
    @(posedge clk);
    #1;
    exp_fv  = 1'b0;
    exp_err = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      if (pend_cap) begin
        m_shadow[pend_slot] = pend_digit;
        m_seen[pend_slot]   = 1'b1;
        exp_err             = (pend_digit == 4'hF);
        if (m_seen == 4'hF) begin
          m_seen = 4'd0;
          model_commit(exp_fv);
        end
      end
      pend_cap = 1'b0;
      if (a == m_last_an && s == m_last_seg) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_run = 1;
      end
      m_last_an  = a;
      m_last_seg = s;
      if (an_valid(a) && m_run == SETTLE) begin
        pend_cap   = 1'b1;
        pend_slot  = an_index(a);
        pend_digit = decode(s);
      end
    end
    if (bus.frame_valid !== exp_fv || bus.seg_error !== exp_err) pulse_skew++;
    if (bus.frame_valid === 1'b1) fv_obs++;
    if (exp_fv) fv_exp++;
    if (bus.seg_error === 1'b1) err_obs++;
    if (exp_err) err_exp++;
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    repeat (n) applyStimulus(a, s, 1'b0);
  endtask

  task automatic scan4(input logic [6:0] m, input logic [6:0] t, input logic [6:0] o,
                       input logic [6:0] d);
    dwell(4'h7, m, 8);
    dwell(4'hB, t, 8);
    dwell(4'hD, o, 8);
    dwell(4'hE, d, 8);
    dwell(4'hF, 7'h7F, 2);
  endtask

  task automatic do_reset();
    applyStimulus(4'hF, 7'h7F, 1'b1);
    applyStimulus(4'hF, 7'h7F, 1'b1);
    applyStimulus(4'hF, 7'h7F, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_compared++;
      if (dut_digit(i) !== 4'h0) begin
        n_mismatched++;
        $display("[TB] FAIL reset_digit%0d: got %h, want 0", i, dut_digit(i));
      end
    end
    n_compared++;
    if (bus.frame_valid !== 1'b0 || bus.seg_error !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_pulses: got fv=%b err=%b, want 0/0", bus.frame_valid, bus.seg_error);
    end
  endtask

`ifdef SEG_SCAN_STABLE_EN
  task automatic test_stable_frames();
    logic [6:0] last [3];
    int fv_before;
    last[0] = 7'h79;
    last[1] = 7'h24;
    last[2] = 7'h24;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      fv_before = fv_obs;
      scan4(7'h40, 7'h40, 7'h40, last[f]);
      n_compared++;
      if (fv_obs - fv_before !== ((f == 2) ? 1 : 0)) begin
        n_mismatched++;
        $display("[TB] FAIL stable_frame%0d_pulses: got %0d, want %0d", f, fv_obs - fv_before, (f == 2) ? 1 : 0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_compared++;
      if (dut_digit(i) !== ((i == 0) ? 4'd2 : 4'd0)) begin
        n_mismatched++;
        $display("[TB] FAIL stable_digit%0d: got %h, want %h", i, dut_digit(i), (i == 0) ? 4'd2 : 4'd0);
      end
    end
  endtask
`else
  task automatic test_scan_basic();
    int fv_before, skew_before;
    do_reset();
    fv_before   = fv_obs;
    skew_before = pulse_skew;
    scan4(7'h79, 7'h24, 7'h30, 7'h19);
    n_compared++;
    if (fv_obs - fv_before !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL scan_pulses: got %0d, want 1", fv_obs - fv_before);
    end
    for (int i = 0; i < 4; i++) begin
      n_compared++;
      if (dut_digit(i) !== 4'(4 - i)) begin
        n_mismatched++;
        $display("[TB] FAIL scan_digit%0d: got %h, want %h", i, dut_digit(i), 4'(4 - i));
      end
    end
    n_compared++;
    if (pulse_skew - skew_before !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL scan_timing: got %0d bad cycles, want 0", pulse_skew - skew_before);
    end
  endtask

  task automatic test_short_dwell();
    int fv_before;
    do_reset();
    fv_before = fv_obs;
    dwell(4'hE, 7'h12, 3);
    dwell(4'hF, 7'h7F, 3);
    dwell(4'h7, 7'h79, 8);
    dwell(4'hB, 7'h24, 8);
    dwell(4'hD, 7'h30, 8);
    n_compared++;
    if (fv_obs - fv_before !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL short_dwell_no_frame: got %0d pulses, want 0", fv_obs - fv_before);
    end
    dwell(4'hE, 7'h19, 8);
    n_compared++;
    if (fv_obs - fv_before !== 1 || bus.Tenths_Seconds !== 4'd4) begin
      n_mismatched++;
      $display("[TB] FAIL short_dwell_frame: got %0d pulses tenths=%h, want 1 and 4",
               fv_obs - fv_before, bus.Tenths_Seconds);
    end
  endtask

  task automatic test_blank_digit();
    int fv_before, err_before;
    do_reset();
    fv_before  = fv_obs;
    err_before = err_obs;
    scan4(7'h79, 7'h7F, 7'h30, 7'h19);
    n_compared++;
    if (err_obs - err_before !== 1 || fv_obs - fv_before !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL blank_pulses: got err=%0d fv=%0d, want 1/1", err_obs - err_before, fv_obs - fv_before);
    end
    n_compared++;
    if (bus.Tens_Seconds !== 4'hF || bus.Minutes !== 4'd1) begin
      n_mismatched++;
      $display("[TB] FAIL blank_digits: got tens=%h min=%h, want F and 1", bus.Tens_Seconds, bus.Minutes);
    end
  endtask

  task automatic test_double_low();
    int fv_before, err_before;
    do_reset();
    fv_before  = fv_obs;
    err_before = err_obs;
    dwell(4'h3, 7'h79, 20);
    dwell(4'h7, 7'h79, 8);
    dwell(4'hB, 7'h24, 8);
    dwell(4'hD, 7'h30, 8);
    n_compared++;
    if (fv_obs - fv_before !== 0 || err_obs - err_before !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL double_low_ignored: got fv=%0d err=%0d, want 0/0", fv_obs - fv_before, err_obs - err_before);
    end
  endtask

  task automatic test_reset_midframe();
    int fv_before;
    do_reset();
    dwell(4'h7, 7'h79, 8);
    dwell(4'hB, 7'h24, 8);
    dwell(4'hD, 7'h30, 8);
    do_reset();
    fv_before = fv_obs;
    dwell(4'hE, 7'h10, 8);
    dwell(4'hD, 7'h10, 8);
    dwell(4'hB, 7'h12, 8);
    n_compared++;
    if (fv_obs - fv_before !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_partial: got %0d pulses, want 0", fv_obs - fv_before);
    end
    dwell(4'h7, 7'h10, 8);
    n_compared++;
    if (fv_obs - fv_before !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_frame: got %0d pulses, want 1", fv_obs - fv_before);
    end
    n_compared++;
    if (bus.Minutes !== 4'd9 || bus.Tens_Seconds !== 4'd5 || bus.Ones_Seconds !== 4'd9 ||
        bus.Tenths_Seconds !== 4'd9) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_digits: got %h%h%h%h, want 9599", bus.Minutes, bus.Tens_Seconds,
               bus.Ones_Seconds, bus.Tenths_Seconds);
    end
  endtask
`endif

  task automatic test_random_scan();
    int cycles, n, pick;
    int skew0, fvo0, fve0, erro0, erre0;
    logic [3:0] a;
    logic [6:0] s;
    do_reset();
    skew0 = pulse_skew;
    fvo0  = fv_obs;
    fve0  = fv_exp;
    erro0 = err_obs;
    erre0 = err_exp;
    cycles = 0;
    while (cycles < 2400) begin
      if ($urandom_range(0, 59) == 0) begin
        applyStimulus(4'hF, 7'h7F, 1'b1);
        cycles++;
      end else begin
        pick = $urandom_range(0, 9);
        if (pick < 7)       a = ~(4'b0001 << $urandom_range(0, 3));
        else if (pick == 7) a = 4'hF;
        else                a = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) < 8) s = pat[$urandom_range(0, 9)];
        else                          s = 7'($urandom_range(0, 127));
        n = $urandom_range(1, 9);
        dwell(a, s, n);
        cycles += n;
      end
    end
    dwell(4'hF, 7'h7F, 3);
    n_compared++;
    if (pulse_skew - skew0 !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL random_pulse_timing: got %0d bad cycles, want 0", pulse_skew - skew0);
    end
    n_compared++;
    if (fv_obs - fvo0 !== fv_exp - fve0) begin
      n_mismatched++;
      $display("[TB] FAIL random_frames: got %0d, want %0d", fv_obs - fvo0, fv_exp - fve0);
    end
    n_compared++;
    if (err_obs - erro0 !== err_exp - erre0) begin
      n_mismatched++;
      $display("[TB] FAIL random_seg_errors: got %0d, want %0d", err_obs - erro0, err_exp - erre0);
    end
    for (int i = 0; i < 4; i++) begin
      n_compared++;
      if (dut_digit(i) !== m_out[i]) begin
        n_mismatched++;
        $display("[TB] FAIL random_digit%0d: got %h, want %h", i, dut_digit(i), m_out[i]);
      end
    end
  endtask

  initial begin
    pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30; pat[4] = 7'h19;
    pat[5] = 7'h12; pat[6] = 7'h02; pat[7] = 7'h78; pat[8] = 7'h00; pat[9] = 7'h10;
    n_compared   = 0;
    n_mismatched = 0;
    pulse_skew   = 0;
    fv_obs = 0; fv_exp = 0; err_obs = 0; err_exp = 0;
    bus.an  = 4'hF;
    bus.Seg = 7'h7F;
    reset   = 1'b1;
    model_reset();

    $display("[TB] starting seg_scan_decoder bench");
    test_reset();
`ifdef SEG_SCAN_STABLE_EN
    test_stable_frames();
`else
    test_scan_basic();
    test_short_dwell();
    test_blank_digit();
    test_double_low();
    test_reset_midframe();
`endif
    test_random_scan();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 4, consecutive stable cycles required before a digit is captured; legal range 1..255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 an  input  4  digit anodes, active-low; an[3]=Minutes, an[2]=Tens_Seconds, an[1]=Ones_Seconds, an[0]=Tenths_Seconds.
REQ-005 Seg  input  7  segments, active-low, Seg[6:0]={g,f,e,d,c,b,a}.
REQ-006 Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds  output  4 each  last committed decoded BCD digits.
REQ-007 frame_valid  output  1  one-cycle pulse when all four digits are committed.
REQ-008 seg_error  output  1  one-cycle pulse when a settled segment pattern is not a legal digit.

Function
REQ-009 an and Seg SHALL be registered once at input; all decisions use the registered copies (1-cycle input latency).
REQ-010 an SHALL be valid only when exactly one bit is 0; other values (4'hF, two or more low) SHALL be ignored and return the FSM to IDLE.
REQ-011 FSM states: IDLE (no valid an), SETTLE (counting stable cycles), HELD (digit captured, waiting for an or Seg change).
REQ-012 IDLE->SETTLE on valid an; counter loaded with 1.
REQ-013 In SETTLE, any change of registered an or Seg SHALL restart the count (valid an) or go to IDLE (invalid an).
REQ-014 SETTLE->HELD when count reaches SETTLE_CYCLES; the decoded digit SHALL be written to the shadow slot selected by an, and the slot's seen bit set, in that same cycle.
REQ-015 HELD->SETTLE on change of an or Seg with valid an; HELD->IDLE on invalid an; one capture maximum per dwell.
REQ-016 Decode active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-017 Any other settled pattern (including blank 7'h7F) SHALL store 4'hF in the shadow slot, set the seen bit, and pulse seg_error the cycle after capture.
REQ-018 When seen==4'b1111 after a capture, shadow SHALL be copied to the outputs, frame_valid pulsed, and seen cleared, all on the cycle after the fourth capture.
REQ-019 A digit captured again before the frame completes SHALL overwrite its shadow slot; seen unchanged.
REQ-020 Outputs SHALL hold their values between commits.

Reset
REQ-021 reset SHALL force FSM=IDLE, counter=0, seen=0, shadow=0, all four digit outputs=4'h0, frame_valid=0, seg_error=0, input registers=an 4'hF/Seg 7'h7F.
REQ-022 reset asserted mid-frame SHALL discard partial shadow data; the next frame starts from seen=0.

Configuration
REQ-023 Macro SEG_SCAN_STABLE_EN: when defined, a completed frame SHALL be committed only if identical to the previous completed frame (first frame after reset never commits); frame_valid pulses only on commit.
REQ-024 Without SEG_SCAN_STABLE_EN, every completed frame SHALL commit (REQ-018); no previous-frame register exists.

Structure
REQ-025 Shared package SHALL hold the ten segment-pattern constants, the blank/invalid code 4'hF, FSM state encoding, and the default SETTLE_CYCLES.
REQ-026 One sub-module, seg7_to_bcd, SHALL implement the combinational pattern-to-digit decode with an invalid flag.

Verification
REQ-027 Scan "1:23.4" (an 7,B,D,E with 7'h79,7'h24,7'h30,7'h19), 8 cycles each -> frame_valid one pulse; outputs 1,2,3,4.
REQ-028 Dwell of 3 cycles with SETTLE_CYCLES=4 on an=4'hE -> no capture; seen unchanged; no frame_valid.
REQ-029 Seg=7'h7F settled on an=4'hB -> seg_error pulse; after frame, Tens_Seconds=4'hF.
REQ-030 an=4'h3 (two digits low) for 20 cycles -> FSM IDLE, no capture, no pulses.
REQ-031 reset asserted after three digits captured, then full scan "9:59.9" -> single frame_valid; outputs 9,5,9,9.
REQ-032 With SEG_SCAN_STABLE_EN: frames "0:00.1","0:00.2","0:00.2" -> frame_valid only on third frame; outputs 0,0,0,2.
